// File: rtl/mem_arbiter_if.sv
// Generic request/response port used for the fetch, data and shared memory sides of mem_arbiter.
// The requester drives the master side and the responder drives the slave side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  fence;
    logic                  spec;
    logic                  instr;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        output fence,
        output spec,
        output instr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        input  fence,
        input  spec,
        input  instr,
        output ready,
        output rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data requesters.
// One pending slot per requester, round-robin on conflict, one outstanding transaction, fetch redirect kill.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  imem,
    mem_arbiter_if.slave  dmem,
    mem_arbiter_if.master mem
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  fence;
    } ireq_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
    } dreq_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
        logic                  fence;
        logic                  instr;
    } mreq_t;

    state_t state_q, state_d;
    logic   ipend_q, ipend_d;
    ireq_t  ireq_q, ireq_d;
    logic   dpend_q, dpend_d;
    dreq_t  dreq_q, dreq_d;
    logic   kill_q, kill_d;
    logic   last_data_q, last_data_d;
    mreq_t  hold_q, hold_d;

    ireq_t  ireq_in;
    dreq_t  dreq_in;
    ireq_t  icur;
    dreq_t  dcur;
    mreq_t  issue_req;
    mreq_t  out_req;
    logic   redirect;
    logic   icand;
    logic   dcand;
    logic   grant_i;
    logic   issue;
    logic   i_done;
    logic   d_done;

    // Request fields the arbiter never consumes on these sides.
    logic unused_inputs;
    assign unused_inputs = ^{imem.wdata, imem.wstrb, imem.instr,
                             dmem.fence, dmem.spec, dmem.instr};

    always_comb begin
        ireq_in.addr  = imem.addr;
        ireq_in.fence = imem.fence;
        dreq_in.addr  = dmem.addr;
        dreq_in.wdata = dmem.wdata;
        dreq_in.wstrb = dmem.wstrb;
    end

    // Next-state, pending-slot and issue logic.
    always_comb begin
        state_d     = state_q;
        ipend_d     = ipend_q;
        ireq_d      = ireq_q;
        dpend_d     = dpend_q;
        dreq_d      = dreq_q;
        kill_d      = kill_q;
        last_data_d = last_data_q;
        hold_d      = hold_q;
        issue_req   = hold_q;
        issue       = 1'b0;
        grant_i     = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;

        redirect = imem.valid & imem.spec;
        icand    = ipend_q | imem.valid;
        dcand    = dpend_q | dmem.valid;
        icur     = imem.valid ? ireq_in : ireq_q;
        dcur     = dpend_q ? dreq_q : dreq_in;

        // Newest fetch always replaces the pending one; a redirect does the same.
        if (imem.valid) begin
            ipend_d = 1'b1;
            ireq_d  = ireq_in;
        end

        // A second data request while one is outstanding is dropped.
        if (dmem.valid && !dpend_q && !(state_q == DBUSY && !mem.ready)) begin
            dpend_d = 1'b1;
            dreq_d  = dreq_in;
        end

        case (state_q)
            IDLE: begin
                if (icand || dcand) begin
                    issue       = 1'b1;
                    grant_i     = icand & (~dcand | last_data_q);
                    last_data_d = ~grant_i;
                    if (grant_i) begin
                        ipend_d         = 1'b0;
                        issue_req.addr  = icur.addr;
                        issue_req.wdata = '0;
                        issue_req.wstrb = '0;
                        issue_req.fence = icur.fence;
                        issue_req.instr = 1'b1;
                        state_d         = IBUSY;
                    end else begin
                        dpend_d         = 1'b0;
                        issue_req.addr  = dcur.addr;
                        issue_req.wdata = dcur.wdata;
                        issue_req.wstrb = dcur.wstrb;
                        issue_req.fence = 1'b0;
                        issue_req.instr = 1'b0;
                        state_d         = DBUSY;
                    end
                    hold_d = issue_req;
                end
            end
            IBUSY: begin
                if (mem.ready) begin
                    i_done  = ~kill_q & ~redirect;
                    kill_d  = 1'b0;
                    state_d = IDLE;
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            DBUSY: begin
                if (mem.ready) begin
                    d_done  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Nothing leaves the block during the reset cycle.
        if (reset) begin
            issue  = 1'b0;
            i_done = 1'b0;
            d_done = 1'b0;
        end

        out_req = issue ? issue_req : hold_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ipend_q     <= 1'b0;
            ireq_q      <= '0;
            dpend_q     <= 1'b0;
            dreq_q      <= '0;
            kill_q      <= 1'b0;
            last_data_q <= 1'b1;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            ipend_q     <= ipend_d;
            ireq_q      <= ireq_d;
            dpend_q     <= dpend_d;
            dreq_q      <= dreq_d;
            kill_q      <= kill_d;
            last_data_q <= last_data_d;
            hold_q      <= hold_d;
        end
    end

    // Issue and responses are combinational so a request in IDLE reaches memory the same cycle.
    assign mem.valid  = issue;
    assign mem.addr   = out_req.addr;
    assign mem.wdata  = out_req.wdata;
    assign mem.wstrb  = out_req.wstrb;
    assign mem.fence  = out_req.fence;
    assign mem.instr  = out_req.instr;
    assign mem.spec   = 1'b0;

    assign imem.ready = i_done;
    assign imem.rdata = i_done ? mem.rdata : '0;
    assign dmem.ready = d_done;
    assign dmem.rdata = d_done ? mem.rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, conflict round-robin, redirect kill, pending overwrite,
// reset mid-transaction and stray memory responses.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) imem_if ();
    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dmem_if ();
    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .imem  (imem_if),
        .dmem  (dmem_if),
        .mem   (mem_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        imem_if.valid = 1'b0;
        imem_if.addr  = '0;
        imem_if.wdata = '0;
        imem_if.wstrb = '0;
        imem_if.fence = 1'b0;
        imem_if.spec  = 1'b0;
        imem_if.instr = 1'b0;
        dmem_if.valid = 1'b0;
        dmem_if.addr  = '0;
        dmem_if.wdata = '0;
        dmem_if.wstrb = '0;
        dmem_if.fence = 1'b0;
        dmem_if.spec  = 1'b0;
        dmem_if.instr = 1'b0;
        mem_if.ready  = 1'b0;
        mem_if.rdata  = '0;
    endtask

    task automatic ifetch(input logic [31:0] addr, input logic spec);
        imem_if.valid = 1'b1;
        imem_if.addr  = addr;
        imem_if.spec  = spec;
    endtask

    task automatic dreq(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        dmem_if.valid = 1'b1;
        dmem_if.addr  = addr;
        dmem_if.wdata = wdata;
        dmem_if.wstrb = wstrb;
    endtask

    task automatic mready(input logic [31:0] rdata);
        mem_if.ready = 1'b1;
        mem_if.rdata = rdata;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();

        // Reset state
        do_reset();
        settle();
        check("rst_mem_valid", 32'(mem_if.valid), 32'h0);
        check("rst_mem_addr", mem_if.addr, 32'h0);
        check("rst_imem_ready", 32'(imem_if.ready), 32'h0);
        check("rst_dmem_ready", 32'(dmem_if.ready), 32'h0);

        // Single fetch, zero-latency issue, response three cycles later
        ifetch(32'h100, 1'b0);
        settle();
        check("f1_valid", 32'(mem_if.valid), 32'h1);
        check("f1_instr", 32'(mem_if.instr), 32'h1);
        check("f1_addr", mem_if.addr, 32'h100);
        check("f1_wstrb", 32'(mem_if.wstrb), 32'h0);
        step(); idle_inputs(); settle();
        check("f1_busy_valid", 32'(mem_if.valid), 32'h0);
        check("f1_busy_addr", mem_if.addr, 32'h100);
        step(); settle();
        step(); mready(32'h13); settle();
        check("f1_iready", 32'(imem_if.ready), 32'h1);
        check("f1_irdata", imem_if.rdata, 32'h13);
        check("f1_dready", 32'(dmem_if.ready), 32'h0);
        step(); idle_inputs();

        // Conflict: instruction first after reset, then data wins over a pending fetch
        do_reset();
        ifetch(32'h200, 1'b0);
        dreq(32'h80, 32'hDEADBEEF, 4'hF);
        settle();
        check("c_first_instr", 32'(mem_if.instr), 32'h1);
        check("c_first_addr", mem_if.addr, 32'h200);
        check("c_first_wdata", mem_if.wdata, 32'h0);
        step(); idle_inputs();
        mready(32'h11);
        ifetch(32'h204, 1'b0);
        settle();
        check("c_iready", 32'(imem_if.ready), 32'h1);
        check("c_irdata", imem_if.rdata, 32'h11);
        check("c_gap_valid", 32'(mem_if.valid), 32'h0);
        step(); idle_inputs(); settle();
        check("c_data_valid", 32'(mem_if.valid), 32'h1);
        check("c_data_instr", 32'(mem_if.instr), 32'h0);
        check("c_data_addr", mem_if.addr, 32'h80);
        check("c_data_wdata", mem_if.wdata, 32'hDEADBEEF);
        check("c_data_wstrb", 32'(mem_if.wstrb), 32'hF);
        step(); mready(32'h22); settle();
        check("c_dready", 32'(dmem_if.ready), 32'h1);
        check("c_d_no_iready", 32'(imem_if.ready), 32'h0);
        step(); idle_inputs(); settle();
        check("c_second_valid", 32'(mem_if.valid), 32'h1);
        check("c_second_addr", mem_if.addr, 32'h204);
        step(); mready(32'h33); settle();
        check("c_second_irdata", imem_if.rdata, 32'h33);
        step(); idle_inputs();

        // Redirect while the fetch is in flight
        do_reset();
        ifetch(32'h300, 1'b0);
        settle();
        check("r_issue_addr", mem_if.addr, 32'h300);
        step(); idle_inputs();
        ifetch(32'h400, 1'b1);
        settle();
        check("r_busy_valid", 32'(mem_if.valid), 32'h0);
        step(); idle_inputs();
        mready(32'hAA);
        settle();
        check("r_killed_iready", 32'(imem_if.ready), 32'h0);
        step(); idle_inputs(); settle();
        check("r_new_valid", 32'(mem_if.valid), 32'h1);
        check("r_new_addr", mem_if.addr, 32'h400);
        step(); mready(32'hBB); settle();
        check("r_new_iready", 32'(imem_if.ready), 32'h1);
        check("r_new_irdata", imem_if.rdata, 32'hBB);
        step(); idle_inputs();

        // Redirect in the same cycle as the in-flight response
        ifetch(32'h600, 1'b0);
        settle();
        step(); idle_inputs();
        mready(32'hCC);
        ifetch(32'h700, 1'b1);
        settle();
        check("rs_drop_iready", 32'(imem_if.ready), 32'h0);
        step(); idle_inputs(); settle();
        check("rs_new_addr", mem_if.addr, 32'h700);
        step(); mready(32'hDD); settle();
        check("rs_new_iready", 32'(imem_if.ready), 32'h1);
        step(); idle_inputs();

        // Pending fetch overwritten while data is in flight
        dreq(32'h90, 32'h0, 4'h0);
        settle();
        check("p_data_instr", 32'(mem_if.instr), 32'h0);
        step(); idle_inputs();
        ifetch(32'h500, 1'b0);
        step(); idle_inputs();
        ifetch(32'h504, 1'b0);
        step(); idle_inputs();
        mready(32'h55);
        settle();
        check("p_dready", 32'(dmem_if.ready), 32'h1);
        check("p_drdata", dmem_if.rdata, 32'h55);
        check("p_no_iready", 32'(imem_if.ready), 32'h0);
        step(); idle_inputs(); settle();
        check("p_fetch_valid", 32'(mem_if.valid), 32'h1);
        check("p_fetch_addr", mem_if.addr, 32'h504);
        step(); mready(32'h66); settle();
        check("p_iready", 32'(imem_if.ready), 32'h1);
        step(); idle_inputs(); settle();
        check("p_no_second_issue", 32'(mem_if.valid), 32'h0);
        check("p_no_second_iready", 32'(imem_if.ready), 32'h0);

        // Reset in the middle of a data transaction
        dreq(32'hA0, 32'h0, 4'h0);
        settle();
        check("x_issue_valid", 32'(mem_if.valid), 32'h1);
        step(); idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mready(32'h77);
        settle();
        check("x_late_dready", 32'(dmem_if.ready), 32'h0);
        check("x_late_valid", 32'(mem_if.valid), 32'h0);
        check("x_late_addr", mem_if.addr, 32'h0);
        step(); idle_inputs();
        ifetch(32'h0, 1'b0);
        settle();
        check("x_fetch_valid", 32'(mem_if.valid), 32'h1);
        check("x_fetch_instr", 32'(mem_if.instr), 32'h1);
        step(); idle_inputs();
        mready(32'h88);
        settle();
        check("x_fetch_iready", 32'(imem_if.ready), 32'h1);
        step(); idle_inputs();

        // Stray memory response in IDLE
        mready(32'h99);
        settle();
        check("s_iready", 32'(imem_if.ready), 32'h0);
        check("s_dready", 32'(dmem_if.ready), 32'h0);
        check("s_valid", 32'(mem_if.valid), 32'h0);
        step(); idle_inputs(); settle();
        check("s_after_valid", 32'(mem_if.valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
